// File: rtl/horizontal_rocket_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : horizontal_rocket_scheduler
// Description : Decides when and where the next horizontal rocket is launched.
//               It counts video frames, waits a pseudo-random gap, latches a
//               random launch slot and emits a one-cycle shootPulse to the
//               horizontal rocket controller. It re-arms only once the
//               controller's rocket is gone, or once the launch is seen as
//               dropped.
// Ports       : clk               - system clock
//               resetN            - asynchronous active-low reset
//               startOfFrame      - one-cycle pulse per video frame
//               isGameMode        - launches happen only while high
//               isAciveHorizontal - rocket-active flag from the controller
//               shootPulse        - one-cycle launch request
//               randLoc           - launch slot 0..3 (bit 2 always 0)
//               warningActive     - pre-launch warning flag
//               shotsFired        - count of emitted pulses (wraps)
// Options     : HROCKET_WARNING_EN - adds the WARN state, which keeps
//               warningActive high for WARN_FRAMES frames before each launch.
// Revision    : 1.0 - initial release
// ============================================================================
module horizontal_rocket_scheduler #(
    parameter int          MIN_GAP_FRAMES = 60,
    parameter int          RAND_GAP_BITS  = 6,
    parameter int          WARN_FRAMES    = 32,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       isGameMode,
    input  logic       isAciveHorizontal,
    output logic       shootPulse,
    output logic [2:0] randLoc,
    output logic       warningActive,
    output logic [7:0] shotsFired
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COUNT      = 3'd1,
        WARN       = 3'd2,
        FIRE       = 3'd3,
        WAIT_ACK   = 3'd4,
        WAIT_CLEAR = 3'd5
    } state_t;

    localparam logic [7:0] c_MIN_GAP   = 8'(MIN_GAP_FRAMES);
    localparam logic [7:0] c_RAND_MASK = 8'((1 << RAND_GAP_BITS) - 1);

    state_t      state_q;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [7:0]  gapCnt_q;
    logic [1:0]  waitCnt_q;
    logic [2:0]  randLoc_q;
    logic [7:0]  shotsFired_q;
    logic [7:0]  w_gap_load;
`ifdef HROCKET_WARNING_EN
    logic [7:0]  warnCnt_q;
`endif

    // Fibonacci LFSR, x^16+x^14+x^13+x^11+1; a non-zero seed keeps it
    // away from the all-zero lock-up state.
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Gap reload value: minimum gap plus a random extra taken from the LFSR.
    assign w_gap_load = c_MIN_GAP + (lfsr_q[7:0] & c_RAND_MASK);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            lfsr_q       <= LFSR_SEED;
            gapCnt_q     <= 8'd0;
            waitCnt_q    <= 2'd0;
            randLoc_q    <= 3'd0;
            shotsFired_q <= 8'd0;
`ifdef HROCKET_WARNING_EN
            warnCnt_q    <= 8'd0;
`endif
        end else begin
            lfsr_q <= lfsr_d;
            // Leaving game mode overrides every transition; randLoc and
            // shotsFired keep their values.
            if (!isGameMode) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        gapCnt_q <= w_gap_load;
                        state_q  <= COUNT;
                    end
                    COUNT: begin
                        if (startOfFrame && (gapCnt_q != 8'd0)) begin
                            gapCnt_q <= gapCnt_q - 8'd1;
                            if (gapCnt_q == 8'd1) begin
                                randLoc_q <= {1'b0, lfsr_q[1:0]};
`ifdef HROCKET_WARNING_EN
                                warnCnt_q <= 8'(WARN_FRAMES);
                                state_q   <= WARN;
`else
                                state_q   <= FIRE;
`endif
                            end
                        end
                    end
                    WARN: begin
`ifdef HROCKET_WARNING_EN
                        if (startOfFrame && (warnCnt_q != 8'd0)) begin
                            warnCnt_q <= warnCnt_q - 8'd1;
                            if (warnCnt_q == 8'd1) begin
                                state_q <= FIRE;
                            end
                        end
`else
                        state_q <= IDLE;
`endif
                    end
                    FIRE: begin
                        // isGameMode is known high here, so the pulse is out.
                        shotsFired_q <= shotsFired_q + 8'd1;
                        waitCnt_q    <= 2'd0;
                        state_q      <= WAIT_ACK;
                    end
                    WAIT_ACK: begin
                        if (isAciveHorizontal) begin
                            state_q <= WAIT_CLEAR;
                        end else begin
                            waitCnt_q <= waitCnt_q + 2'd1;
                            // Third cycle without an acknowledge: the
                            // controller ignored the launch, so re-arm.
                            if (waitCnt_q == 2'd2) begin
                                gapCnt_q <= w_gap_load;
                                state_q  <= COUNT;
                            end
                        end
                    end
                    WAIT_CLEAR: begin
                        if (!isAciveHorizontal) begin
                            gapCnt_q <= w_gap_load;
                            state_q  <= COUNT;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Pulse and warning are gated by isGameMode so that both drop in the
    // very cycle game mode is left.
    assign shootPulse = (state_q == FIRE) && isGameMode;
`ifdef HROCKET_WARNING_EN
    assign warningActive = (state_q == WARN) && isGameMode;
`else
    assign warningActive = 1'b0;
`endif
    assign randLoc    = randLoc_q;
    assign shotsFired = shotsFired_q;

endmodule
`default_nettype wire

// File: tb/tb_horizontal_rocket_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_horizontal_rocket_scheduler
// Description : Self-checking bench for horizontal_rocket_scheduler. The
//               reference is kept at launch level: gap length, launch slot,
//               warning window and shot count come from a behavioural LFSR
//               and the launch rules, driven by randomized frame spacing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_horizontal_rocket_scheduler;

    localparam int          MIN  = 2;
    localparam int          RB   = 1;
    localparam int          WF   = 4;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef HROCKET_WARNING_EN
    localparam int WARN_ON = 1;
`else
    localparam int WARN_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       sof = 1'b0;
    logic       gm = 1'b0;
    logic       act = 1'b0;
    logic       shootPulse;
    logic [2:0] randLoc;
    logic       warningActive;
    logic [7:0] shotsFired;

    int          total = 0;
    int          bad = 0;
    int          pulse_cnt = 0;
    logic [7:0]  exp_shots = 8'd0;
    logic [2:0]  prev_loc = 3'd0;
    logic [15:0] m_lfsr;

    horizontal_rocket_scheduler #(
        .MIN_GAP_FRAMES (MIN),
        .RAND_GAP_BITS  (RB),
        .WARN_FRAMES    (WF),
        .LFSR_SEED      (SEED)
    ) dut (
        .clk               (clk),
        .resetN            (resetN),
        .startOfFrame      (sof),
        .isGameMode        (gm),
        .isAciveHorizontal (act),
        .shootPulse        (shootPulse),
        .randLoc           (randLoc),
        .warningActive     (warningActive),
        .shotsFired        (shotsFired)
    );

    always #5 clk = ~clk;

    // Reference LFSR: the polynomial stepped once per clock from the seed.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) m_lfsr <= SEED;
        else         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    // Counts clock cycles with shootPulse high.
    always @(negedge clk) begin
        if (shootPulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just before the edge that loads the gap. Drives frames until the
    // launch and checks warning window, slot latch, pulse and shot count.
    task automatic launch(input int spacing, input bit drop_fire);
        int         g;
        int         f;
        int         sp;
        int         base;
        logic [2:0] eloc;
        logic       exp_w;
        g    = MIN + int'(m_lfsr[RB-1:0]);
        f    = g + WARN_ON * WF;
        base = pulse_cnt;
        eloc = prev_loc;
        sof  = 1'b0;
        tick();
        for (int i = 1; i <= f; i++) begin
            sof = 1'b1;
            if (i == g) eloc = {1'b0, m_lfsr[1:0]};
            tick();
            sof = 1'b0;
            exp_w = (WARN_ON != 0) && (i >= g) && (i < f);
            total++;
            if (warningActive !== exp_w) begin
                bad++;
                $display("FAIL warn frame=%0d got=%b exp=%b", i, warningActive, exp_w);
            end
            total++;
            if (randLoc !== eloc) begin
                bad++;
                $display("FAIL randLoc frame=%0d got=%0d exp=%0d", i, randLoc, eloc);
            end
            if (i < f) begin
                sp = (spacing > 0) ? spacing : int'($urandom_range(2, 12));
                repeat (sp - 1) tick();
                total++;
                if (pulse_cnt != base) begin
                    bad++;
                    $display("FAIL early_pulse frame=%0d got=%0d exp=%0d", i, pulse_cnt - base, 0);
                end
            end
        end
        prev_loc = eloc;
        if (drop_fire) begin
            gm = 1'b0;
            #1;
            total++;
            if (shootPulse !== 1'b0) begin
                bad++;
                $display("FAIL drop_pulse got=%b exp=0", shootPulse);
            end
            tick();
            total++;
            if (shotsFired !== exp_shots) begin
                bad++;
                $display("FAIL drop_shots got=%0d exp=%0d", shotsFired, exp_shots);
            end
            total++;
            if (pulse_cnt != base) begin
                bad++;
                $display("FAIL drop_count got=%0d exp=%0d", pulse_cnt - base, 0);
            end
        end else begin
            total++;
            if (shootPulse !== 1'b1 || warningActive !== 1'b0) begin
                bad++;
                $display("FAIL fire got=%b/%b exp=1/0", shootPulse, warningActive);
            end
            sof = 1'($urandom_range(0, 1));
            tick();
            sof = 1'b0;
            exp_shots = exp_shots + 8'd1;
            total++;
            if (shootPulse !== 1'b0) begin
                bad++;
                $display("FAIL pulse_width got=%b exp=0", shootPulse);
            end
            total++;
            if (shotsFired !== exp_shots) begin
                bad++;
                $display("FAIL shots got=%0d exp=%0d", shotsFired, exp_shots);
            end
            total++;
            if (pulse_cnt != base + 1) begin
                bad++;
                $display("FAIL pulse_count got=%0d exp=%0d", pulse_cnt - base, 1);
            end
        end
    endtask

    // From WAIT_ACK with no acknowledge: two more edges, then the re-arm edge.
    task automatic skip_wait_ack();
        repeat (2) begin
            sof = 1'($urandom_range(0, 1));
            tick();
        end
        sof = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        total++;
        if (shootPulse !== 1'b0 || warningActive !== 1'b0 || randLoc !== 3'd0 || shotsFired !== 8'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b/%b/%0d/%0d exp=0/0/0/0", shootPulse, warningActive, randLoc, shotsFired);
        end
        total++;
        if (dut.lfsr_q !== SEED) begin
            bad++;
            $display("FAIL reset_lfsr got=%h exp=%h", dut.lfsr_q, SEED);
        end
        #2 resetN = 1'b1;
        repeat ($urandom_range(2, 6)) tick();
        total++;
        if (pulse_cnt != 0 || shotsFired !== 8'd0) begin
            bad++;
            $display("FAIL idle_no_game got=%0d/%0d exp=0/0", pulse_cnt, shotsFired);
        end
    endtask

    task automatic test_basic_launch();
        gm = 1'b1;
        launch(16, 1'b0);
    endtask

    task automatic test_ack_cycle();
        int base;
        base = pulse_cnt;
        act = 1'b1;
        tick();
        repeat (5) begin
            sof = 1'b1;
            tick();
            sof = 1'b0;
            repeat (15) tick();
        end
        total++;
        if (pulse_cnt != base) begin
            bad++;
            $display("FAIL ack_hold got=%0d exp=%0d", pulse_cnt - base, 0);
        end
        act = 1'b0;
        launch(16, 1'b0);
    endtask

    task automatic test_dropped_launch();
        repeat (4) begin
            skip_wait_ack();
            launch(0, 1'b0);
        end
    endtask

    task automatic test_game_mode_drop();
        int         base;
        logic [7:0] s;
        skip_wait_ack();
        launch(0, 1'b1);
        base = pulse_cnt;
        s    = shotsFired;
        repeat ($urandom_range(1, 5)) begin
            sof = 1'($urandom_range(0, 1));
            tick();
        end
        sof = 1'b0;
        total++;
        if (pulse_cnt != base || shotsFired !== s) begin
            bad++;
            $display("FAIL idle_hold got=%0d/%0d exp=0/%0d", pulse_cnt - base, shotsFired, s);
        end
        gm = 1'b1;
        launch(0, 1'b0);
    endtask

    task automatic test_wrap();
        int n;
        n = 256 - int'(exp_shots);
        repeat (n) begin
            skip_wait_ack();
            launch(2, 1'b0);
        end
        total++;
        if (shotsFired !== 8'd0) begin
            bad++;
            $display("FAIL wrap got=%0d exp=0", shotsFired);
        end
    endtask

    task automatic test_reset_mid();
        int g;
        int n;
        int base;
        skip_wait_ack();
        launch(2, 1'b0);
        gm = 1'b0;
        tick();
        gm = 1'b1;
        g = MIN + int'(m_lfsr[RB-1:0]);
        tick();
        n = (WARN_ON != 0) ? g + 1 : g - 1;
        for (int j = 0; j < n; j++) begin
            sof = 1'b1;
            tick();
            sof = 1'b0;
            repeat (3) tick();
        end
        total++;
        if (warningActive !== 1'(WARN_ON)) begin
            bad++;
            $display("FAIL pre_reset_warn got=%b exp=%0d", warningActive, WARN_ON);
        end
        base = pulse_cnt;
        #3 resetN = 1'b0;
        #1;
        total++;
        if (shootPulse !== 1'b0 || warningActive !== 1'b0 || randLoc !== 3'd0 || shotsFired !== 8'd0) begin
            bad++;
            $display("FAIL async_reset got=%b/%b/%0d/%0d exp=0/0/0/0", shootPulse, warningActive, randLoc, shotsFired);
        end
        total++;
        if (dut.lfsr_q !== SEED) begin
            bad++;
            $display("FAIL async_lfsr got=%h exp=%h", dut.lfsr_q, SEED);
        end
        #2 resetN = 1'b1;
        exp_shots = 8'd0;
        prev_loc  = 3'd0;
        launch(0, 1'b0);
        total++;
        if (pulse_cnt != base + 1) begin
            bad++;
            $display("FAIL reset_no_pulse got=%0d exp=%0d", pulse_cnt - base, 1);
        end
    endtask

    initial begin
        test_reset();
        test_basic_launch();
        test_ack_cycle();
        test_dropped_launch();
        test_game_mode_drop();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/horizontal_rocket_scheduler.md
# horizontal_rocket_scheduler

Decides when and where the next horizontal rocket is launched and drives `shootPulse`/`randLoc` into the horizontal rocket controller. It counts frames, picks a pseudo-random gap and launch location, optionally flags a pre-launch warning, then waits until the controller's rocket is gone before re-arming. It sits directly upstream of the horizontal rocket controller, between the frame-timing logic and that controller.

## Interface
- `MIN_GAP_FRAMES`, 60, minimum frames between launches (≥1).
- `RAND_GAP_BITS`, 6, random extra gap of 0..2^N−1 frames; `MIN_GAP_FRAMES + 2^RAND_GAP_BITS − 1 ≤ 255`.
- `WARN_FRAMES`, 32, warning length in frames (≥1; used only with the macro).
- `LFSR_SEED`, 16'hACE1, LFSR reset value (non-zero).
- `clk` in 1: system clock; the single clock.
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: one-cycle pulse per video frame.
- `isGameMode` in 1: level; launches occur only while high.
- `isAciveHorizontal` in 1: active flag fed back from the controller.
- `shootPulse` out 1: one-cycle launch request.
- `randLoc` out 3: launch slot 0..3; bit 2 is always 0.
- `warningActive` out 1: high during the pre-launch warning.
- `shotsFired` out 8: count of emitted pulses.

## Operation
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, advances every clock, loads `LFSR_SEED` on reset, never reaches zero.
- `gapCnt`: 8 bits. `warnCnt`: 8 bits. `waitCnt`: 2 bits.
- States: IDLE, COUNT, WARN, FIRE, WAIT_ACK, WAIT_CLEAR.
- IDLE: if `isGameMode`, then `gapCnt ← MIN_GAP_FRAMES + lfsr[RAND_GAP_BITS-1:0]` and go to COUNT.
- COUNT: on `startOfFrame`, decrement `gapCnt`. When the decrement takes `gapCnt` from 1 to 0:
  - latch `randLoc ← {1'b0, lfsr[1:0]}`;
  - with the macro, `warnCnt ← WARN_FRAMES` and go to WARN;
  - without the macro, go to FIRE.
- WARN: `warningActive` = 1. On `startOfFrame`, decrement `warnCnt`. The 1→0 transition goes to FIRE.
- FIRE: one cycle. `shootPulse = (state==FIRE) && isGameMode`. `shotsFired` increments when the pulse is emitted and wraps 255→0. Next state is WAIT_ACK with `waitCnt ← 0`.
- WAIT_ACK:
  - if `isAciveHorizontal`, go to WAIT_CLEAR;
  - otherwise increment `waitCnt`; at 3, the launch is treated as dropped (controller priority lost) and the block reloads `gapCnt` and goes to COUNT.
- WAIT_CLEAR: when `isAciveHorizontal` = 0, reload `gapCnt` as in IDLE and go to COUNT.
- `isGameMode` = 0 in any state forces IDLE on the next edge, overriding every other transition. `warningActive` and `shootPulse` are 0 in that same cycle. `randLoc` and `shotsFired` hold.
- `randLoc` changes only at the latch point and is stable from the latch through FIRE and until the next latch.

## Timing
- Reset values: state IDLE, `shootPulse` 0, `randLoc` 0, `warningActive` 0, `shotsFired` 0, counters 0, LFSR = `LFSR_SEED`.
- Reset mid-operation returns all of the above to reset values immediately (asynchronous); no pulse is emitted.
- Latency: the edge that samples the final `startOfFrame` (COUNT without the macro, WARN with it) enters FIRE; `shootPulse` is high in the following cycle for exactly 1 clock.
- `startOfFrame` arriving in the FIRE cycle or during the WAIT states is ignored.
- Gap timing is measured from entering COUNT:
  - without the macro, the pulse follows the G-th `startOfFrame`, where G = loaded `gapCnt`;
  - with the macro, it follows the (G + WARN_FRAMES)-th.
- At most one `shootPulse` is emitted per rocket lifetime.

## Configuration
- `HROCKET_WARNING_EN` defined: the WARN state exists, and `warningActive` is high from COUNT exit until FIRE (WARN_FRAMES frames).
- Not defined: COUNT goes directly to FIRE, `warningActive` is tied to 0, and `warnCnt` is not instantiated.

## Test plan
- Reset check: assert `resetN` = 0 mid-WARN → all outputs 0 asynchronously; after release, state is IDLE and the LFSR equals 16'hACE1.
- Basic launch: `MIN_GAP_FRAMES`=2, `RAND_GAP_BITS`=1, macro off, `isGameMode`=1, `startOfFrame` every 16 cycles.
  - Required: a 1-cycle `shootPulse` after the 2nd or 3rd frame pulse; `randLoc` ≤ 3 and stable; `shotsFired` = 1.
- Acknowledge cycle: drive `isAciveHorizontal` = 1 one cycle after the pulse and hold it for 5 frames → no new pulse. Drop it to 0 → the next pulse comes 2–3 frames later.
- Dropped launch: keep `isAciveHorizontal` = 0 → WAIT_ACK times out after 3 cycles and the block re-arms; pulses repeat every 2–3 frames.
- Warning on: macro on, `WARN_FRAMES`=4 → `warningActive` is high for exactly 4 frame pulses, then `shootPulse` fires the cycle after the 4th.
- Game-mode drop: deassert `isGameMode` in the FIRE cycle → no pulse; `shotsFired` unchanged; state is IDLE next cycle. Force `shotsFired` to 255, then fire → it wraps to 0.
